// File: rtl/sprite_compositor_pkg.sv
// Shared constants, flash FSM state type and the
// box/rectangle hit tests used by sprite_compositor.
package sprite_compositor_pkg;

  localparam logic [7:0] RED         = 8'hE0;
  localparam logic [7:0] YELLOW      = 8'hFC;
  localparam logic [7:0] BG_COLOR    = 8'hFB;
  localparam logic [7:0] FLASH_COLOR = 8'hFF;
  localparam logic [7:0] BLANK       = 8'h00;

  localparam logic [3:0] ST_ATTACK_END  = 4'd4;
  localparam logic [3:0] ST_ATTACK_PULL = 4'd5;

  // Coordinates are zero-extended to this width for the tests
  localparam int CMAX = 16;
  typedef logic [CMAX-1:0] coord_t;

  typedef enum logic {
    FL_IDLE,
    FL_FLASH
  } flash_st_e;

  function automatic logic in_rect(
    input coord_t px,
    input coord_t py,
    input coord_t ox,
    input coord_t oy,
    input coord_t w,
    input coord_t h
  );
    logic [CMAX:0] xe;
    logic [CMAX:0] ye;
    xe = {1'b0, ox} + {1'b0, w};
    ye = {1'b0, oy} + {1'b0, h};
    return (px >= ox) && ({1'b0, px} < xe) &&
           (py >= oy) && ({1'b0, py} < ye);
  endfunction

  function automatic logic on_border(
    input coord_t px,
    input coord_t py,
    input coord_t x1,
    input coord_t x2,
    input coord_t y1,
    input coord_t y2
  );
    logic in_x;
    logic in_y;
    in_x = (px >= x1) && (px <= x2);
    in_y = (py >= y1) && (py <= y2);
    return ((px == x1 || px == x2) && in_y) ||
           ((py == y1 || py == y2) && in_x);
  endfunction

endpackage

// File: rtl/sprite_compositor_flash.sv
// Per-player hit-flash FSM; hits are deferred to the
// next frame_start so the flash never tears mid-frame.
module hit_flash_fsm
  import sprite_compositor_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_SHIFT  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic hit_pulse,
  output logic flash_phase
);

  flash_st_e  st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pend_d = pend_q | hit_pulse;
    if (frame_start) begin
      // a coincident hit waits for the next frame
      pend_d = hit_pulse;
      if (pend_q) begin
        st_d  = FL_FLASH;
        cnt_d = 8'(FLASH_FRAMES);
      end else if (st_q == FL_FLASH) begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) st_d = FL_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= FL_IDLE;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign flash_phase = (st_q == FL_FLASH) & cnt_q[FLASH_SHIFT];

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: sprites, hit/hurt box
// outlines and background, with per-player hit flash.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int COORD_W      = 10,
  parameter int COLOR_W      = 8,
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_SHIFT  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  input  logic [NUM_PLAYERS*COORD_W-1:0] spr_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] spr_y,
  input  logic [NUM_PLAYERS*COORD_W-1:0] spr_w,
  input  logic [NUM_PLAYERS*COORD_W-1:0] spr_h,
  input  logic [NUM_PLAYERS*COLOR_W-1:0] spr_data,
  input  logic [NUM_PLAYERS-1:0]         spr_vis,
  input  logic [NUM_PLAYERS*4*COORD_W-1:0] hurt_box,
  input  logic [NUM_PLAYERS*4*COORD_W-1:0] hit_box,
  input  logic [NUM_PLAYERS*4-1:0]       player_state,
  input  logic [NUM_PLAYERS-1:0]         hit_pulse,
  input  logic                           debug_en,
  output logic [COLOR_W-1:0]             color_out,
  output logic                           color_valid
);

  localparam int NP = NUM_PLAYERS;
  localparam int W  = COORD_W;
  localparam int B  = 4 * COORD_W;

  logic [NP-1:0] phase;

  for (genvar g = 0; g < NP; g++) begin : g_fsm
    hit_flash_fsm #(
      .FLASH_FRAMES (FLASH_FRAMES),
      .FLASH_SHIFT  (FLASH_SHIFT)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .hit_pulse   (hit_pulse[g]),
      .flash_phase (phase[g])
    );
  end

  logic [NP-1:0] red_d, yel_d, hurt_d, spr_d;
  logic [NP-1:0] red_q, yel_q, hurt_q, spr_q, fl_q;
  logic [NP*COLOR_W-1:0] data_q;
  logic                  vld_q;
  logic [COLOR_W-1:0]    col, color_d;

  always_comb begin
    red_d  = '0;
    yel_d  = '0;
    hurt_d = '0;
    spr_d  = '0;
    for (int i = 0; i < NP; i++) begin
      if (on_border(coord_t'(pix_x), coord_t'(pix_y),
                    coord_t'(hit_box[i*B+3*W +: W]),
                    coord_t'(hit_box[i*B+2*W +: W]),
                    coord_t'(hit_box[i*B+W +: W]),
                    coord_t'(hit_box[i*B +: W]))) begin
        red_d[i] = player_state[i*4 +: 4] == ST_ATTACK_END;
        yel_d[i] = player_state[i*4 +: 4] == ST_ATTACK_PULL;
      end
      hurt_d[i] = debug_en &&
        on_border(coord_t'(pix_x), coord_t'(pix_y),
                  coord_t'(hurt_box[i*B+3*W +: W]),
                  coord_t'(hurt_box[i*B+2*W +: W]),
                  coord_t'(hurt_box[i*B+W +: W]),
                  coord_t'(hurt_box[i*B +: W]));
      spr_d[i] = spr_vis[i] &&
        in_rect(coord_t'(pix_x), coord_t'(pix_y),
                coord_t'(spr_x[i*W +: W]),
                coord_t'(spr_y[i*W +: W]),
                coord_t'(spr_w[i*W +: W]),
                coord_t'(spr_h[i*W +: W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q  <= '0;
      yel_q  <= '0;
      hurt_q <= '0;
      spr_q  <= '0;
      fl_q   <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      red_q  <= red_d;
      yel_q  <= yel_d;
      hurt_q <= hurt_d;
      spr_q  <= spr_d;
      fl_q   <= phase;
      data_q <= spr_data;
      vld_q  <= pix_valid;
    end
  end

  // Later assignments win: weakest rule first,
  // and within a rule the highest index first.
  always_comb begin
    col = COLOR_W'(BG_COLOR);
    for (int i = NP - 1; i >= 0; i--)
      if (spr_q[i])
        col = fl_q[i] ? COLOR_W'(FLASH_COLOR)
                      : data_q[i*COLOR_W +: COLOR_W];
    for (int i = NP - 1; i >= 0; i--)
      if (hurt_q[i]) col = COLOR_W'(YELLOW);
    for (int i = NP - 1; i >= 0; i--)
      if (yel_q[i]) col = COLOR_W'(YELLOW);
    for (int i = NP - 1; i >= 0; i--)
      if (red_q[i]) col = COLOR_W'(RED);
    color_d = vld_q ? col : COLOR_W'(BLANK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_out   <= '0;
      color_valid <= 1'b0;
    end else begin
      color_out   <= color_d;
      color_valid <= vld_q;
    end
  end

endmodule
